// File: rtl/floo_multi_chan_link_mux.sv
// Multiplexes NumChan logical NoC channels onto one physical link: per-channel FIFO and
// credit counter, round-robin packet arbitration with wormhole lock. FLOO_LINK_MUX_PERF_EN adds flit counters.

module floo_link_mux_chan #(
    parameter int unsigned DataWidth  = 64,
    parameter int unsigned FifoDepth  = 2,
    parameter int unsigned NumCredits = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 push_i,
    input  logic [DataWidth-1:0] data_i,
    input  logic                 last_i,
    input  logic                 pop_i,
    input  logic                 credit_i,
    output logic                 full_o,
    output logic                 empty_o,
    output logic                 has_credit_o,
    output logic [DataWidth-1:0] head_data_o,
    output logic                 head_last_o,
    output logic                 credit_ovf_o
);
    localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int unsigned CntW = $clog2(FifoDepth + 1);
    localparam int unsigned CrW  = $clog2(NumCredits + 1);

    typedef struct packed {
        logic [DataWidth-1:0] data;
        logic                 last;
    } entry_t;

    entry_t          mem_q [FifoDepth];
    entry_t          mem_d [FifoDepth];
    logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [CrW-1:0]  credit_q, credit_d;
    logic            credit_full;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(FifoDepth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o       = (cnt_q == CntW'(FifoDepth));
    assign empty_o      = (cnt_q == '0);
    assign has_credit_o = (credit_q != '0);
    assign credit_full  = (credit_q == CrW'(NumCredits));
    assign credit_ovf_o = credit_i && !pop_i && credit_full;
    assign head_data_o  = mem_q[rptr_q].data;
    assign head_last_o  = mem_q[rptr_q].last;

    always_comb begin
        mem_d    = mem_q;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        cnt_d    = cnt_q;
        credit_d = credit_q;
        if (push_i) begin
            mem_d[wptr_q] = '{data: data_i, last: last_i};
            wptr_d        = ptr_inc(wptr_q);
        end
        if (pop_i) rptr_d = ptr_inc(rptr_q);
        if (push_i && !pop_i)      cnt_d = cnt_q + 1'b1;
        else if (!push_i && pop_i) cnt_d = cnt_q - 1'b1;
        // A send and a returned credit in the same cycle cancel out; excess returns saturate.
        if (pop_i && !credit_i)                     credit_d = credit_q - 1'b1;
        else if (credit_i && !pop_i && !credit_full) credit_d = credit_q + 1'b1;
    end

    always_ff @(posedge clk_i) mem_q <= mem_d;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            cnt_q    <= '0;
            credit_q <= CrW'(NumCredits);
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            cnt_q    <= cnt_d;
            credit_q <= credit_d;
        end
    end
endmodule

module floo_multi_chan_link_mux #(
    parameter int unsigned NumChan     = 3,
    parameter int unsigned DataWidth   = 64,
    parameter int unsigned FifoDepth   = 2,
    parameter int unsigned NumCredits  = 4,
    parameter int unsigned ChanIdWidth = $clog2(NumChan)
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NumChan-1:0]             valid_i,
    output logic [NumChan-1:0]             ready_o,
    input  logic [NumChan*DataWidth-1:0]   data_i,
    input  logic [NumChan-1:0]             last_i,
    output logic                           link_valid_o,
    output logic [ChanIdWidth-1:0]         link_chan_o,
    output logic [DataWidth-1:0]           link_data_o,
    output logic                           link_last_o,
    input  logic [NumChan-1:0]             credit_i,
    output logic                           credit_err_o,
    output logic [NumChan*32-1:0]          perf_flits_o
);
    logic [NumChan-1:0]                push, pop, full, empty, has_cred, ovf, elig, head_last;
    logic [NumChan-1:0][DataWidth-1:0] head_data;

    logic                   gnt_vld;
    logic [ChanIdWidth-1:0] gnt_idx, cidx;
    int unsigned            cand;

    logic                   link_valid_q, link_valid_d, link_last_q, link_last_d;
    logic [ChanIdWidth-1:0] link_chan_q, link_chan_d;
    logic [DataWidth-1:0]   link_data_q, link_data_d;
    logic                   lock_q, lock_d, credit_err_q, credit_err_d;
    logic [ChanIdWidth-1:0] lock_chan_q, lock_chan_d, rr_q, rr_d;

    assign ready_o = ~full;
    assign push    = valid_i & ~full;
    assign elig    = ~empty & has_cred;

    for (genvar c = 0; c < NumChan; c++) begin : g_chan
        floo_link_mux_chan #(
            .DataWidth (DataWidth),
            .FifoDepth (FifoDepth),
            .NumCredits(NumCredits)
        ) i_chan (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .push_i      (push[c]),
            .data_i      (data_i[c*DataWidth +: DataWidth]),
            .last_i      (last_i[c]),
            .pop_i       (pop[c]),
            .credit_i    (credit_i[c]),
            .full_o      (full[c]),
            .empty_o     (empty[c]),
            .has_credit_o(has_cred[c]),
            .head_data_o (head_data[c]),
            .head_last_o (head_last[c]),
            .credit_ovf_o(ovf[c])
        );
    end

    // A locked packet owns the link even while its channel is stalled.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = 0;
        cidx    = '0;
        if (lock_q) begin
            gnt_vld = elig[lock_chan_q];
            gnt_idx = lock_chan_q;
        end else begin
            for (int unsigned i = 0; i < NumChan; i++) begin
                cand = (32'(rr_q) + i) % NumChan;
                cidx = ChanIdWidth'(cand);
                if (!gnt_vld && elig[cidx]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = cidx;
                end
            end
        end
        pop = '0;
        if (gnt_vld) pop[gnt_idx] = 1'b1;
    end

    always_comb begin
        link_valid_d = gnt_vld;
        link_chan_d  = link_chan_q;
        link_data_d  = link_data_q;
        link_last_d  = link_last_q;
        lock_d       = lock_q;
        lock_chan_d  = lock_chan_q;
        rr_d         = rr_q;
        credit_err_d = credit_err_q | (|ovf);
        if (gnt_vld) begin
            link_chan_d = gnt_idx;
            link_data_d = head_data[gnt_idx];
            link_last_d = head_last[gnt_idx];
            if (head_last[gnt_idx]) begin
                lock_d = 1'b0;
                rr_d   = (gnt_idx == ChanIdWidth'(NumChan - 1)) ? '0 : gnt_idx + 1'b1;
            end else begin
                lock_d      = 1'b1;
                lock_chan_d = gnt_idx;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            link_valid_q <= 1'b0;
            link_chan_q  <= '0;
            link_data_q  <= '0;
            link_last_q  <= 1'b0;
            lock_q       <= 1'b0;
            lock_chan_q  <= '0;
            rr_q         <= '0;
            credit_err_q <= 1'b0;
        end else begin
            link_valid_q <= link_valid_d;
            link_chan_q  <= link_chan_d;
            link_data_q  <= link_data_d;
            link_last_q  <= link_last_d;
            lock_q       <= lock_d;
            lock_chan_q  <= lock_chan_d;
            rr_q         <= rr_d;
            credit_err_q <= credit_err_d;
        end
    end

    assign link_valid_o = link_valid_q;
    assign link_chan_o  = link_chan_q;
    assign link_data_o  = link_data_q;
    assign link_last_o  = link_last_q;
    assign credit_err_o = credit_err_q;

`ifdef FLOO_LINK_MUX_PERF_EN
    logic [NumChan-1:0][31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        for (int unsigned c = 0; c < NumChan; c++) begin
            if (pop[c]) perf_d[c] = perf_q[c] + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) perf_q <= '0;
        else         perf_q <= perf_d;
    end

    assign perf_flits_o = perf_q;
`else
    assign perf_flits_o = '0;
`endif
endmodule

// File: tb/tb_floo_multi_chan_link_mux.sv
// Scoreboard bench for floo_multi_chan_link_mux: directed traffic, expected link flits queued in
// link order, an independent negedge monitor pops and compares every link flit.

module tb_floo_multi_chan_link_mux;
    logic         clk;
    logic         rst_ni;
    logic [2:0]   valid_i, ready_o, last_i, credit_i;
    logic [191:0] data_i;
    logic         link_valid_o, link_last_o, credit_err_o;
    logic [1:0]   link_chan_o;
    logic [63:0]  link_data_o;
    logic [95:0]  perf_flits_o;

    typedef struct packed {
        logic [63:0] data;
        logic        last;
    } in_t;

    typedef struct packed {
        logic [1:0]  chan;
        logic [63:0] data;
        logic        last;
    } flit_t;

    in_t   in_q [3][$];
    flit_t exp_q[$];
    int    pass_cnt = 0;
    int    tot_cnt  = 0;

    floo_multi_chan_link_mux dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .data_i      (data_i),
        .last_i      (last_i),
        .link_valid_o(link_valid_o),
        .link_chan_o (link_chan_o),
        .link_data_o (link_data_o),
        .link_last_o (link_last_o),
        .credit_i    (credit_i),
        .credit_err_o(credit_err_o),
        .perf_flits_o(perf_flits_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic put(input int c, input logic [63:0] d, input logic l);
        in_q[c].push_back('{data: d, last: l});
    endtask

    task automatic want(input int c, input logic [63:0] d, input logic l);
        exp_q.push_back('{chan: 2'(c), data: d, last: l});
    endtask

    // Drive queued flits (valid held until accepted) plus credit pulses for one clock.
    task automatic step(input logic [2:0] cred);
        for (int c = 0; c < 3; c++) begin
            if (in_q[c].size() > 0) begin
                valid_i[c]         = 1'b1;
                data_i[c*64 +: 64] = in_q[c][0].data;
                last_i[c]          = in_q[c][0].last;
            end else begin
                valid_i[c] = 1'b0;
            end
        end
        credit_i = cred;
        @(posedge clk);
        for (int c = 0; c < 3; c++) begin
            if (rst_ni && valid_i[c] && ready_o[c]) void'(in_q[c].pop_front());
        end
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step(3'b000);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        for (int c = 0; c < 3; c++) in_q[c].delete();
        step(3'b000);
        step(3'b000);
        rst_ni = 1'b1;
    endtask

    // Monitor: every link flit must be the next expected one.
    initial begin
        forever begin
            @(negedge clk);
            if (link_valid_o) begin
                if (exp_q.size() == 0) begin
                    tot_cnt++;
                    $display("FAIL link_unexpected: got chan %0d data %0h, expected no flit",
                             link_chan_o, link_data_o);
                end else begin
                    flit_t e;
                    e = exp_q.pop_front();
                    chk("link_flit", {link_chan_o, link_data_o, link_last_o}, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0] cr;
        rst_ni   = 1'b0;
        valid_i  = '0;
        data_i   = '0;
        last_i   = '0;
        credit_i = '0;

        do_reset();
        chk("rst_link_valid", link_valid_o, 0);
        chk("rst_link_chan", link_chan_o, 0);
        chk("rst_link_data", link_data_o, 0);
        chk("rst_link_last", link_last_o, 0);
        chk("rst_credit_err", credit_err_o, 0);
        chk("rst_ready", ready_o, 3'b111);
        chk("rst_perf", perf_flits_o, 0);

        // Single flit on ch1: visible exactly two cycles after acceptance, one cycle wide.
        put(1, 64'h1111, 1'b1);
        want(1, 64'h1111, 1'b1);
        step(3'b000);
        chk("lat_cycle1_idle", link_valid_o, 0);
        step(3'b000);
        chk("lat_cycle2_valid", link_valid_o, 1);
        chk("lat_cycle2_chan", link_chan_o, 1);
        step(3'b000);
        chk("single_cycle_valid", link_valid_o, 0);
        chk("idle_data_hold", link_data_o, 64'h1111);
        chk("drain_single", exp_q.size(), 0);

        // Wormhole: ch0 3-flit packet stays contiguous; then RR serves ch1, ch2 before ch0.
        do_reset();
        put(0, 64'hA0, 1'b0); put(0, 64'hA1, 1'b0); put(0, 64'hA2, 1'b1); put(0, 64'hA3, 1'b1);
        put(1, 64'hC0, 1'b1);
        put(2, 64'hB0, 1'b1); put(2, 64'hB1, 1'b1); put(2, 64'hB2, 1'b1);
        want(0, 64'hA0, 1'b0); want(0, 64'hA1, 1'b0); want(0, 64'hA2, 1'b1);
        want(1, 64'hC0, 1'b1); want(2, 64'hB0, 1'b1); want(0, 64'hA3, 1'b1);
        want(2, 64'hB1, 1'b1); want(2, 64'hB2, 1'b1);
        steps(16);
        chk("drain_wormhole", exp_q.size(), 0);

        // Credits: 6 flits on ch0 with no returns -> 4 sent, FIFO fills, one return releases the 5th.
        do_reset();
        for (int i = 0; i < 6; i++) put(0, 64'hD0 + 64'(i), 1'b1);
        for (int i = 0; i < 4; i++) want(0, 64'hD0 + 64'(i), 1'b1);
        steps(16);
        chk("drain_credit_four", exp_q.size(), 0);
        chk("credit_stall_ready", ready_o, 3'b110);
        want(0, 64'hD4, 1'b1);
        step(3'b001);
        chk("credit_resume_not_yet", link_valid_o, 0);
        step(3'b000);
        chk("credit_resume_valid", link_valid_o, 1);
        steps(6);
        chk("drain_credit_resume", exp_q.size(), 0);
        chk("no_credit_err", credit_err_o, 0);

        // Credit overflow on ch2: sticky error, counter saturates at 4.
        step(3'b100);
        chk("credit_err_set", credit_err_o, 1);
        steps(3);
        chk("credit_err_sticky", credit_err_o, 1);
        for (int i = 0; i < 5; i++) put(2, 64'hE0 + 64'(i), 1'b1);
        for (int i = 0; i < 4; i++) want(2, 64'hE0 + 64'(i), 1'b1);
        steps(16);
        chk("drain_credit_sat", exp_q.size(), 0);
        chk("credit_err_still", credit_err_o, 1);

        // Reset in the middle of a 4-flit ch0 packet after two flits went out.
        do_reset();
        chk("rst_clears_err", credit_err_o, 0);
        put(0, 64'hF0, 1'b0); put(0, 64'hF1, 1'b0); put(0, 64'hF2, 1'b0); put(0, 64'hF3, 1'b1);
        want(0, 64'hF0, 1'b0); want(0, 64'hF1, 1'b0);
        steps(3);
        rst_ni = 1'b0;
        for (int c = 0; c < 3; c++) in_q[c].delete();
        step(3'b000);
        chk("midrst_link_valid", link_valid_o, 0);
        chk("midrst_link_data", link_data_o, 0);
        chk("midrst_ready", ready_o, 3'b111);
        rst_ni = 1'b1;
        put(2, 64'h6060, 1'b1);
        want(2, 64'h6060, 1'b1);
        step(3'b000);
        chk("midrst_new_idle", link_valid_o, 0);
        step(3'b000);
        chk("midrst_new_valid", link_valid_o, 1);
        chk("midrst_new_chan", link_chan_o, 2);
        for (int i = 0; i < 4; i++) begin
            put(0, 64'h70 + 64'(i), 1'b1);
            want(0, 64'h70 + 64'(i), 1'b1);
        end
        steps(12);
        chk("drain_midrst", exp_q.size(), 0);

        // Perf counters: 10 flits on ch1, credits returned as flits appear.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            put(1, 64'h900 + 64'(i), 1'b1);
            want(1, 64'h900 + 64'(i), 1'b1);
        end
        for (int i = 0; i < 30; i++) begin
            cr = (link_valid_o && link_chan_o == 2'd1) ? 3'b010 : 3'b000;
            step(cr);
        end
        chk("drain_perf", exp_q.size(), 0);
        chk("perf_no_err", credit_err_o, 0);
`ifdef FLOO_LINK_MUX_PERF_EN
        chk("perf_ch0", perf_flits_o[31:0], 0);
        chk("perf_ch1", perf_flits_o[63:32], 10);
        chk("perf_ch2", perf_flits_o[95:64], 0);
`else
        chk("perf_tied_zero", perf_flits_o, 0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
